// File: rtl/sfp_pkg.sv
// Shared constants for the SFP receive path.
//   SFP_SYNC_BYTE / SFP_ID_BCAST : framing constants
//   SFP_*_MSB/LSB                : field positions inside a 64-bit word
//   SFP_CNT_W, sfp_cnt_t         : status counter width and type
//   sfp_sat_inc                  : saturating counter increment
package sfp_pkg;

  localparam int unsigned SFP_DATA_W = 64;
  localparam int unsigned SFP_CNT_W  = 16;

  localparam logic [7:0] SFP_SYNC_BYTE = 8'hA5;
  localparam logic [1:0] SFP_ID_BCAST  = 2'b11;

  localparam int unsigned SFP_SYNC_MSB = 63;
  localparam int unsigned SFP_SYNC_LSB = 56;
  localparam int unsigned SFP_DEST_MSB = 55;
  localparam int unsigned SFP_DEST_LSB = 54;
  localparam int unsigned SFP_SEQ_MSB  = 53;
  localparam int unsigned SFP_SEQ_LSB  = 48;

  typedef logic [SFP_CNT_W-1:0] sfp_cnt_t;

  function automatic sfp_cnt_t sfp_sat_inc(input sfp_cnt_t cnt, input logic en);
    if (en && (cnt != '1)) begin
      return cnt + sfp_cnt_t'(1);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sfp_rx_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through output stage.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_flush            : drop all stored words and the output word
//   i_push, i_wdata    : write request (ignored while o_full)
//   o_full             : no room for a push this cycle (already accounts for a pop)
//   o_tdata, o_tvalid  : registered AXI-Stream output
//   i_tready           : downstream ready
// The output register counts toward Depth, so at most Depth words are held in total.
module sfp_rx_fifo
  import sfp_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned DataW = SFP_DATA_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [DataW-1:0] i_wdata,
  output logic             o_full,
  output logic [DataW-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             i_tready
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] DepthCnt = (AW+1)'(Depth);
  localparam logic [AW:0] CntOne   = (AW+1)'(1);

  logic [DataW-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d, occ;
  logic             out_valid_q;
  logic [DataW-1:0] out_data_q;
  logic             pop, load, do_push;

  always_comb begin
    pop     = out_valid_q && i_tready;
    // Refill the output register whenever it is empty or being drained.
    load    = (cnt_q != '0) && (!out_valid_q || pop);
    occ     = cnt_q + {{AW{1'b0}}, out_valid_q};
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    o_full  = (occ == DepthCnt) && !pop;
    do_push = i_push && !o_full;
    cnt_d   = cnt_q;
    if (do_push) cnt_d = cnt_d + CntOne;
    if (load)    cnt_d = cnt_d - CntOne;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        out_data_q  <= mem_q[rd_ptr_q];
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_tdata  = out_data_q;
  assign o_tvalid = out_valid_q;

endmodule

// File: rtl/sfp_rx_guard.sv
// Receive guard between Aurora RX (no backpressure) and the SFP handler stream.
// Registers each RX beat, drops words with a bad sync byte or foreign destination,
// buffers accepted words in sfp_rx_fifo, tracks sequence continuity and link silence.
//   i_clk, i_rst               : clock, asynchronous active-high reset
//   i_channel_up, i_sfp_id     : link status, local node ID
//   i_stat_clr                 : clears counters, sticky flag and sequence tracker
//   s_rx_tdata/tvalid          : Aurora RX input
//   m_sfp_tdata/tvalid/tready  : registered output stream
//   o_*_cnt                    : saturating 16-bit status counters
//   o_link_timeout, o_ovf_sticky : status flags
module sfp_rx_guard
  import sfp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_channel_up,
  input  logic [1:0]            i_sfp_id,
  input  logic                  i_stat_clr,
  input  logic [SFP_DATA_W-1:0] s_rx_tdata,
  input  logic                  s_rx_tvalid,
  output logic [SFP_DATA_W-1:0] m_sfp_tdata,
  output logic                  m_sfp_tvalid,
  input  logic                  m_sfp_tready,
  output logic [SFP_CNT_W-1:0]  o_rx_ok_cnt,
  output logic [SFP_CNT_W-1:0]  o_drop_sync_cnt,
  output logic [SFP_CNT_W-1:0]  o_drop_id_cnt,
  output logic [SFP_CNT_W-1:0]  o_seq_err_cnt,
  output logic [SFP_CNT_W-1:0]  o_ovf_cnt,
  output logic                  o_link_timeout,
  output logic                  o_ovf_sticky
);

  localparam int unsigned   WdW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYC);

  logic                  beat_valid_q;
  logic [SFP_DATA_W-1:0] beat_data_q;
  logic [7:0]            beat_sync;
  logic [1:0]            beat_dest;
  logic [5:0]            beat_seq;

  logic live, sync_ok, id_ok, accept, fifo_full;
  logic ok_evt, ovf_evt, drop_sync_evt, drop_id_evt, seq_err_evt;

  logic       seq_first_q, seq_first_d;
  logic [5:0] seq_exp_q, seq_exp_d;

  sfp_cnt_t ok_q, ok_d, dsync_q, dsync_d, did_q, did_d, serr_q, serr_d, ovf_q, ovf_d;
  logic     sticky_q, sticky_d;
  logic [WdW-1:0] wd_q, wd_d;

  assign beat_sync = beat_data_q[SFP_SYNC_MSB:SFP_SYNC_LSB];
  assign beat_dest = beat_data_q[SFP_DEST_MSB:SFP_DEST_LSB];
  assign beat_seq  = beat_data_q[SFP_SEQ_MSB:SFP_SEQ_LSB];

  always_comb begin
    // A beat captured just before the link fell is discarded with the flush.
    live          = beat_valid_q && i_channel_up;
    sync_ok       = (beat_sync == SFP_SYNC_BYTE);
    id_ok         = (beat_dest == i_sfp_id) || (beat_dest == SFP_ID_BCAST);
    accept        = live && sync_ok && id_ok;
    drop_sync_evt = live && !sync_ok;
    drop_id_evt   = live && sync_ok && !id_ok;
    ok_evt        = accept && !fifo_full;
    ovf_evt       = accept && fifo_full;
    seq_err_evt   = accept && !seq_first_q && (beat_seq != seq_exp_q);

    seq_first_d = seq_first_q;
    seq_exp_d   = seq_exp_q;
    if (i_stat_clr || !i_channel_up) begin
      seq_first_d = 1'b1;
    end else if (accept) begin
      seq_first_d = 1'b0;
      seq_exp_d   = beat_seq + 6'd1;
    end

    if (i_stat_clr) begin
      ok_d     = '0;
      dsync_d  = '0;
      did_d    = '0;
      serr_d   = '0;
      ovf_d    = '0;
      sticky_d = 1'b0;
    end else begin
      ok_d     = sfp_sat_inc(ok_q, ok_evt);
      dsync_d  = sfp_sat_inc(dsync_q, drop_sync_evt);
      did_d    = sfp_sat_inc(did_q, drop_id_evt);
      serr_d   = sfp_sat_inc(serr_q, seq_err_evt);
      ovf_d    = sfp_sat_inc(ovf_q, ovf_evt);
      sticky_d = sticky_q || ovf_evt;
    end

    wd_d = wd_q;
    if (!i_channel_up || s_rx_tvalid) begin
      wd_d = '0;
    end else if (wd_q != WdLimit) begin
      wd_d = wd_q + WdW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_valid_q <= 1'b0;
      beat_data_q  <= '0;
      seq_first_q  <= 1'b1;
      seq_exp_q    <= '0;
      ok_q         <= '0;
      dsync_q      <= '0;
      did_q        <= '0;
      serr_q       <= '0;
      ovf_q        <= '0;
      sticky_q     <= 1'b0;
      wd_q         <= '0;
    end else begin
      beat_valid_q <= s_rx_tvalid && i_channel_up;
      if (s_rx_tvalid) beat_data_q <= s_rx_tdata;
      seq_first_q  <= seq_first_d;
      seq_exp_q    <= seq_exp_d;
      ok_q         <= ok_d;
      dsync_q      <= dsync_d;
      did_q        <= did_d;
      serr_q       <= serr_d;
      ovf_q        <= ovf_d;
      sticky_q     <= sticky_d;
      wd_q         <= wd_d;
    end
  end

  sfp_rx_fifo #(
    .Depth (FIFO_DEPTH),
    .DataW (SFP_DATA_W)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_flush  (!i_channel_up),
    .i_push   (accept),
    .i_wdata  (beat_data_q),
    .o_full   (fifo_full),
    .o_tdata  (m_sfp_tdata),
    .o_tvalid (m_sfp_tvalid),
    .i_tready (m_sfp_tready)
  );

  assign o_rx_ok_cnt     = ok_q;
  assign o_drop_sync_cnt = dsync_q;
  assign o_drop_id_cnt   = did_q;
  assign o_seq_err_cnt   = serr_q;
  assign o_ovf_cnt       = ovf_q;
  assign o_ovf_sticky    = sticky_q;
  assign o_link_timeout  = i_channel_up && (wd_q == WdLimit);

endmodule

// File: tb/tb_sfp_rx_guard.sv
module tb_sfp_rx_guard;

  localparam int unsigned Depth = 16;
  localparam int unsigned Tmo   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        channel_up;
  logic [1:0]  sfp_id;
  logic        stat_clr;
  logic [63:0] rx_tdata;
  logic        rx_tvalid;
  logic [63:0] sfp_tdata;
  logic        sfp_tvalid;
  logic        sfp_tready;
  logic [15:0] ok_cnt, dsync_cnt, did_cnt, serr_cnt, ovf_cnt;
  logic        link_timeout, ovf_sticky;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] got[$];
  logic [63:0] exp_w[$];

  always #5 clk = ~clk;

  sfp_rx_guard #(
    .FIFO_DEPTH  (Depth),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_channel_up    (channel_up),
    .i_sfp_id        (sfp_id),
    .i_stat_clr      (stat_clr),
    .s_rx_tdata      (rx_tdata),
    .s_rx_tvalid     (rx_tvalid),
    .m_sfp_tdata     (sfp_tdata),
    .m_sfp_tvalid    (sfp_tvalid),
    .m_sfp_tready    (sfp_tready),
    .o_rx_ok_cnt     (ok_cnt),
    .o_drop_sync_cnt (dsync_cnt),
    .o_drop_id_cnt   (did_cnt),
    .o_seq_err_cnt   (serr_cnt),
    .o_ovf_cnt       (ovf_cnt),
    .o_link_timeout  (link_timeout),
    .o_ovf_sticky    (ovf_sticky)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w);
    rx_tvalid = 1'b1;
    rx_tdata  = w;
    tick();
    rx_tvalid = 1'b0;
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) tick();
    check("wait_for_words", 64'(got.size()), 64'(n));
  endtask

  function automatic logic [63:0] mk(input logic [7:0] s, input logic [1:0] d,
                                     input logic [5:0] q, input int p);
    return {s, d, q, 16'hBEEF, 32'(p)};
  endfunction

  // Output monitor: records handshakes and checks data holds while stalled.
  logic        stall_prev = 1'b0;
  logic [63:0] data_prev;
  always @(negedge clk) begin
    if (stall_prev && channel_up && !rst) begin
      check("stall_hold", {sfp_tvalid, sfp_tdata}, {1'b1, data_prev});
    end
    if (sfp_tvalid && sfp_tready) got.push_back(sfp_tdata);
    stall_prev = sfp_tvalid && !sfp_tready;
    data_prev  = sfp_tdata;
  end

  typedef struct {
    logic [1:0] id;
    logic [7:0] sync;
    logic [1:0] dest;
    logic [5:0] seq;
    logic [3:0] delta;  // {rx_ok, drop_sync, drop_id, seq_err} increments
  } vec_t;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[15];
    logic [63:0] w;
    logic [15:0] ok0, ds0, di0, se0;

    vt[0]  = '{2'd1, 8'hA5, 2'd1, 6'd0,  4'b1000};
    vt[1]  = '{2'd1, 8'h5A, 2'd1, 6'd1,  4'b0100};
    vt[2]  = '{2'd1, 8'hA5, 2'd2, 6'd1,  4'b0010};
    vt[3]  = '{2'd1, 8'hA5, 2'd3, 6'd1,  4'b1000};
    vt[4]  = '{2'd1, 8'h5A, 2'd2, 6'd9,  4'b0100};
    vt[5]  = '{2'd1, 8'hA5, 2'd1, 6'd2,  4'b1000};
    vt[6]  = '{2'd1, 8'hA5, 2'd1, 6'd5,  4'b1001};
    vt[7]  = '{2'd1, 8'hA5, 2'd1, 6'd6,  4'b1000};
    vt[8]  = '{2'd1, 8'hA5, 2'd0, 6'd7,  4'b0010};
    vt[9]  = '{2'd1, 8'hA5, 2'd1, 6'd7,  4'b1000};
    vt[10] = '{2'd1, 8'hA5, 2'd1, 6'd63, 4'b1001};
    vt[11] = '{2'd1, 8'hA5, 2'd1, 6'd0,  4'b1000};
    vt[12] = '{2'd2, 8'hA5, 2'd2, 6'd1,  4'b1000};
    vt[13] = '{2'd2, 8'hA5, 2'd1, 6'd2,  4'b0010};
    vt[14] = '{2'd0, 8'h00, 2'd0, 6'd2,  4'b0100};

    rst = 1'b1; channel_up = 1'b1; sfp_id = 2'd1; stat_clr = 1'b0;
    rx_tdata = '0; rx_tvalid = 1'b0; sfp_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Reset state
    check("rst_tvalid", 64'(sfp_tvalid), 64'd0);
    check("rst_tdata", sfp_tdata, 64'd0);
    check("rst_ok", 64'(ok_cnt), 64'd0);
    check("rst_dsync", 64'(dsync_cnt), 64'd0);
    check("rst_did", 64'(did_cnt), 64'd0);
    check("rst_serr", 64'(serr_cnt), 64'd0);
    check("rst_ovf", 64'(ovf_cnt), 64'd0);
    check("rst_flags", {62'd0, link_timeout, ovf_sticky}, 64'd0);

    // 20 back-to-back valid words, ready held high
    sfp_tready = 1'b1;
    exp_w.delete(); got.delete();
    for (int i = 0; i < 20; i++) begin
      w = mk(8'hA5, 2'd1, 6'(i), 1000 + i);
      exp_w.push_back(w);
      rx_tvalid = 1'b1;
      rx_tdata  = w;
      tick();
      if (i == 1) check("latency_edge1", 64'(sfp_tvalid), 64'd0);
      if (i == 2) check("latency_edge2", 64'(sfp_tvalid), 64'd1);
    end
    rx_tvalid = 1'b0;
    wait_got(20, 40);
    for (int i = 0; i < 20 && i < got.size(); i++) check("stream_word", got[i], exp_w[i]);
    repeat (3) tick();
    check("stream_ok", 64'(ok_cnt), 64'd20);
    check("stream_others", {dsync_cnt, did_cnt, serr_cnt, ovf_cnt}, 64'd0);

    // Accept rule and sequence tracker, one beat per vector
    pulse_clr();
    tick();
    for (int v = 0; v < 15; v++) begin
      sfp_id = vt[v].id;
      ok0 = ok_cnt; ds0 = dsync_cnt; di0 = did_cnt; se0 = serr_cnt;
      got.delete();
      w = mk(vt[v].sync, vt[v].dest, vt[v].seq, v);
      send(w);
      repeat (5) tick();
      check($sformatf("vec%0d_counts", v),
            {ok_cnt - ok0, dsync_cnt - ds0, did_cnt - di0, serr_cnt - se0},
            {15'd0, vt[v].delta[3], 15'd0, vt[v].delta[2],
             15'd0, vt[v].delta[1], 15'd0, vt[v].delta[0]});
      check($sformatf("vec%0d_fwd", v), 64'(got.size()), 64'(vt[v].delta[3]));
      if (got.size() == 1) check($sformatf("vec%0d_word", v), got[0], w);
    end
    sfp_id = 2'd1;

    // Overflow: 20 beats into a stalled 16-deep buffer
    pulse_clr();
    sfp_tready = 1'b0;
    exp_w.delete(); got.delete();
    for (int i = 0; i < 20; i++) begin
      w = mk(8'hA5, 2'd1, 6'(i), 2000 + i);
      exp_w.push_back(w);
      send(w);
    end
    repeat (4) tick();
    check("ovf_ok", 64'(ok_cnt), 64'd16);
    check("ovf_cnt", 64'(ovf_cnt), 64'd4);
    check("ovf_sticky", 64'(ovf_sticky), 64'd1);
    check("ovf_head", {63'd0, sfp_tvalid}, 64'd1);
    check("ovf_head_data", sfp_tdata, exp_w[0]);
    // Push lands in the same cycle a pop frees a slot
    w = mk(8'hA5, 2'd1, 6'd20, 2020);
    send(w);
    sfp_tready = 1'b1;
    tick();
    sfp_tready = 1'b0;
    repeat (3) tick();
    check("pushpop_ok", 64'(ok_cnt), 64'd17);
    check("pushpop_ovf", 64'(ovf_cnt), 64'd4);
    sfp_tready = 1'b1;
    wait_got(17, 40);
    for (int i = 0; i < 16 && i < got.size(); i++) check("ovf_word", got[i], exp_w[i]);
    if (got.size() >= 17) check("pushpop_word", got[16], w);

    // Link drop flushes queued words
    sfp_tready = 1'b0;
    for (int i = 21; i < 29; i++) send(mk(8'hA5, 2'd1, 6'(i), 3000 + i));
    repeat (4) tick();
    check("flush_pre_valid", 64'(sfp_tvalid), 64'd1);
    channel_up = 1'b0;
    tick();
    check("flush_valid", 64'(sfp_tvalid), 64'd0);
    send(mk(8'h00, 2'd2, 6'd29, 3029));
    repeat (3) tick();
    check("down_ignored", {ok_cnt, dsync_cnt, did_cnt, 15'd0, link_timeout},
          {16'd25, 16'd0, 16'd0, 16'd0});
    channel_up = 1'b1;
    sfp_tready = 1'b1;
    got.delete();
    repeat (2) tick();
    w = mk(8'hA5, 2'd1, 6'd50, 3050);
    send(w);
    repeat (6) tick();
    check("relink_count", 64'(got.size()), 64'd1);
    if (got.size() >= 1) check("relink_word", got[0], w);
    check("relink_seq", 64'(serr_cnt), 64'd0);
    check("relink_ok", 64'(ok_cnt), 64'd26);

    // Watchdog
    send(mk(8'hA5, 2'd1, 6'd51, 4051));
    repeat (Tmo - 1) tick();
    check("tmo_before", 64'(link_timeout), 64'd0);
    tick();
    check("tmo_reached", 64'(link_timeout), 64'd1);
    repeat (10) tick();
    check("tmo_hold", 64'(link_timeout), 64'd1);
    send(mk(8'hA5, 2'd1, 6'd52, 4052));
    check("tmo_clear", 64'(link_timeout), 64'd0);
    repeat (4) tick();

    // Statistics clear
    check("pre_clr", {ok_cnt, ovf_cnt, 31'd0, ovf_sticky}, {16'd28, 16'd4, 32'd1});
    pulse_clr();
    tick();
    check("clr_counts", {ok_cnt, dsync_cnt, did_cnt, serr_cnt}, 64'd0);
    check("clr_ovf", {47'd0, ovf_cnt, ovf_sticky}, 64'd0);
    send(mk(8'hA5, 2'd1, 6'd5, 5005));
    repeat (4) tick();
    check("clr_seq_restart", {ok_cnt, serr_cnt}, {16'd1, 16'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
